regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the CPU pipeline register file.
- Adds a configurable number of read ports and optional write-to-read bypass.
- Adds a per-register pending scoreboard for long-latency producers, and a sequential sweep-clear engine.
- Sits in the ID stage. Writeback drives the write port, issue logic drives the scoreboard set port, and the ILA/debug logic drives the debug port.

Parameters:
- DATA_WIDTH, 64, register data width in bits.
- ADDR_WIDTH, 4, register address width; depth = 2**ADDR_WIDTH.
- NUM_RPORTS, 3, number of read ports (1..8).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = none.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- raddr  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RPORTS*DATA_WIDTH  read data, same packing as raddr.
- rpend  out  NUM_RPORTS  pending flag for each read port.
- wena  in  1  write enable.
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- iss_ena  in  1  mark iss_addr pending.
- iss_addr  in  ADDR_WIDTH  destination being issued.
- clr_start  in  1  one-cycle request to start the sweep-clear.
- clr_busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- pend_cnt  out  ADDR_WIDTH+1  registered count of pending registers.
- dbg_addr  in  ADDR_WIDTH  debug/ILA probe address.
- dbg_data  out  DATA_WIDTH  debug/ILA probe data.

Behaviour:
- Reset (asynchronous, any time including mid-sweep):
  - All registers = 0 and all pending bits = 0.
  - pend_cnt = 0, clr_busy = 0, clr_done = 0, FSM = IDLE.
- Reads are combinational:
  - rdata[i] = regs[raddr[i]].
  - If BYPASS=1, wena is accepted, and waddr == raddr[i], then rdata[i] = wdata.
- rpend[i] = pending[raddr[i]].
  - Exception: when BYPASS=1 and an accepted write matches raddr[i], rpend[i] = 0.
- dbg_data = regs[dbg_addr]. Never bypassed, never gated by the FSM.
- Write: an accepted wena writes regs[waddr] <= wdata at the rising edge and clears pending[waddr]. No address is special; address 0 is writable.
- Issue: an accepted iss_ena sets pending[iss_addr] at the rising edge.
  - If set and clear hit the same address in the same cycle, the set wins (the newer producer owns the register).
- pend_cnt equals the population count of the pending vector after each edge. It is registered and updates on the same edge as the pending bits.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE:
    - wena and iss_ena are accepted.
    - clr_start -> SWEEP with sweep pointer = 0. Writes and issues in the clr_start cycle are still accepted.
  - SWEEP:
    - clr_busy = 1.
    - Each edge: regs[ptr] <= 0, pending[ptr] <= 0, ptr += 1.
    - wena, iss_ena and clr_start are ignored: no state change, no bypass, no rpend masking.
    - After the edge that clears entry 2**ADDR_WIDTH-1 -> DONE.
    - The sweep lasts exactly 2**ADDR_WIDTH cycles.
  - DONE:
    - clr_done = 1 for one cycle, clr_busy = 0, inputs accepted as in IDLE.
    - Next state IDLE; a clr_start here restarts SWEEP.
- clr_busy and clr_done are decoded from registered FSM state, so they are glitch-free.
- Pointer width is ADDR_WIDTH; no wrap beyond the last entry.

Test Plan:
- Reset then read: rst pulse, raddr ports = 0,5,15 -> rdata all 0, rpend all 0, pend_cnt 0.
- Write then read:
  - wena, waddr=3, wdata=0xDEAD_BEEF, raddr[0]=3 -> rdata[0]=0xDEADBEEF in the same cycle (bypass).
  - With BYPASS=0 the same stimulus gives the old value that cycle and 0xDEADBEEF after the edge.
- Scoreboard:
  - iss_ena addr 7 -> rpend=1 on a port reading 7, pend_cnt=1.
  - Later wena addr 7 -> rpend=0 in that cycle with bypass, pend_cnt=0 after the edge.
  - Simultaneous iss_ena and wena to addr 9 -> pending[9]=1, regs[9]=wdata.
- Sweep:
  - Fill all 16 registers with non-zero values, mark 4 pending, pulse clr_start.
  - clr_busy stays high for 16 cycles; wena to addr 2 mid-sweep is ignored.
  - clr_done pulses 1 cycle; all regs = 0, pend_cnt = 0.
- Reset mid-sweep: assert rst at cycle 5 of the sweep -> immediate clr_busy=0, all regs 0, FSM in IDLE, next clr_start sweeps normally.
- Multi-port/debug: NUM_RPORTS=3, all ports and dbg_addr on addr 4 -> identical data; dbg_data is not bypassed during a write to 4.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: ID-stage register file with configurable read ports, optional
// write-to-read bypass, a per-register pending scoreboard for long-latency
// producers, and a sequential sweep-clear engine that zeroes every entry.

module regfile_sb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RPORTS = 3,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rpend,
  input  logic                             wena,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             iss_ena,
  input  logic [ADDR_WIDTH-1:0]            iss_addr,
  input  logic                             clr_start,
  output logic                             clr_busy,
  output logic                             clr_done,
  output logic [ADDR_WIDTH:0]              pend_cnt,
  input  logic [ADDR_WIDTH-1:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0]            dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]        pending_q, pending_d;
  logic [ADDR_WIDTH:0]     pend_cnt_q, pend_cnt_d;

  logic                    sweeping;
  logic                    accept;
  logic                    wr_fire;
  logic                    iss_fire;
  logic [ADDR_WIDTH-1:0]   rd_addr [NUM_RPORTS];

  // Writes and issues are only honoured outside the sweep; the sweep owns the array.
  always_comb begin
    sweeping = (state_q == SWEEP);
    accept   = !sweeping;
    wr_fire  = accept && wena;
    iss_fire = accept && iss_ena;
  end

  // FSM state register plus sweep pointer; reset may land at any time, including mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: IDLE/DONE launch a sweep on clr_start, SWEEP walks every entry once.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_ONE;
        end
      end
      DONE: begin
        if (clr_start) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM outputs decoded from registered state only, so they never glitch.
  always_comb begin
    clr_busy = (state_q == SWEEP);
    clr_done = (state_q == DONE);
  end

  // Register array next value: writeback outside the sweep, zeroing of the swept entry inside it.
  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[waddr] = wdata;
    end
    if (sweeping) begin
      regs_d[ptr_q] = '0;
    end
  end

  // Register array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Scoreboard next value: writeback retires, issue claims; issue applied last so the newer producer wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_fire) begin
      pending_d[waddr] = 1'b0;
    end
    if (iss_fire) begin
      pending_d[iss_addr] = 1'b1;
    end
    if (sweeping) begin
      pending_d[ptr_q] = 1'b0;
    end
  end

  // Pending count is the popcount of the next scoreboard, so it lands on the same edge.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + (ADDR_WIDTH + 1)'(pending_d[i]);
    end
  end

  // Scoreboard and pending count storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Unpack the per-port read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_addr[i] = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Combinational read ports; a same-cycle accepted write to the same entry is forwarded and shows as not pending.
  always_comb begin
    rdata = '0;
    rpend = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      if ((BYPASS != 0) && wr_fire && (waddr == rd_addr[i])) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
        rpend[i]                          = 1'b0;
      end else begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[i]];
        rpend[i]                          = pending_q[rd_addr[i]];
      end
    end
  end

  // Debug probe shows stored state only: never forwarded, never blocked by the sweep.
  always_comb begin
    dbg_data = regs_q[dbg_addr];
    pend_cnt = pend_cnt_q;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb. A second instance
// with BYPASS=0 shares all inputs so forwarding can be compared side by side.

module tb_regfile_sb;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NR = 3;

  logic           clk;
  logic           rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_nb;
  logic [NR-1:0]  rpend, rpend_nb;
  logic           wena;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           iss_ena;
  logic [AW-1:0]  iss_addr;
  logic           clr_start;
  logic           clr_busy, clr_busy_nb;
  logic           clr_done, clr_done_nb;
  logic [AW:0]    pend_cnt, pend_cnt_nb;
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_data, dbg_data_nb;

  int checks;
  int failures;

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NR), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .wena(wena), .waddr(waddr), .wdata(wdata), .iss_ena(iss_ena), .iss_addr(iss_addr),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .pend_cnt(pend_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RPORTS(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rpend(rpend_nb),
    .wena(wena), .waddr(waddr), .wdata(wdata), .iss_ena(iss_ena), .iss_addr(iss_addr),
    .clr_start(clr_start), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb), .pend_cnt(pend_cnt_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_nb(input int p);
    return rdata_nb[p*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raddr = {4'd15, 4'd5, 4'd0};
    step();
    step();
    rst = 1'b0;
    step();
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd(p) !== '0) begin
        failures++;
        $display("[TB] FAIL reset_rdata%0d: got %h expected 0", p, rd(p));
      end
    end
    checks++;
    if (rpend !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_rpend: got %b expected 000", rpend);
    end
    checks++;
    if (pend_cnt !== 5'd0 || pend_cnt_nb !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_pend_cnt: got %0d/%0d expected 0", pend_cnt, pend_cnt_nb);
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || clr_busy_nb !== 1'b0 || clr_done_nb !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_fsm: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
  endtask

  task automatic test_write_read();
    wena = 1'b1;
    waddr = 4'd3;
    wdata = 64'hDEAD_BEEF;
    raddr = {4'd15, 4'd5, 4'd3};
    #1;
    checks++;
    if (rd(0) !== 64'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL write_bypass: got %h expected deadbeef", rd(0));
    end
    checks++;
    if (rd_nb(0) !== 64'h0) begin
      failures++;
      $display("[TB] FAIL write_nobypass_old: got %h expected 0", rd_nb(0));
    end
    step();
    wena = 1'b0;
    #1;
    checks++;
    if (rd_nb(0) !== 64'hDEAD_BEEF || rd(0) !== 64'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL write_after_edge: got %h/%h expected deadbeef", rd(0), rd_nb(0));
    end
  endtask

  task automatic test_scoreboard();
    iss_ena = 1'b1;
    iss_addr = 4'd7;
    raddr = {4'd9, 4'd7, 4'd3};
    step();
    iss_ena = 1'b0;
    #1;
    checks++;
    if (rpend[1] !== 1'b1 || pend_cnt !== 5'd1) begin
      failures++;
      $display("[TB] FAIL issue_pending: got rpend=%b cnt=%0d expected 1 1", rpend[1], pend_cnt);
    end
    wena = 1'b1;
    waddr = 4'd7;
    wdata = 64'h1234;
    #1;
    checks++;
    if (rpend[1] !== 1'b0 || rd(1) !== 64'h1234) begin
      failures++;
      $display("[TB] FAIL retire_bypass: got rpend=%b data=%h expected 0 1234", rpend[1], rd(1));
    end
    checks++;
    if (rpend_nb[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL retire_nobypass_rpend: got %b expected 1", rpend_nb[1]);
    end
    step();
    wena = 1'b0;
    #1;
    checks++;
    if (pend_cnt !== 5'd0 || rpend[1] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL retire_after_edge: got cnt=%0d rpend=%b expected 0 0", pend_cnt, rpend[1]);
    end
    iss_ena = 1'b1;
    iss_addr = 4'd9;
    wena = 1'b1;
    waddr = 4'd9;
    wdata = 64'h9999;
    step();
    iss_ena = 1'b0;
    wena = 1'b0;
    #1;
    checks++;
    if (rpend[2] !== 1'b1 || rd(2) !== 64'h9999 || pend_cnt !== 5'd1) begin
      failures++;
      $display("[TB] FAIL set_wins: got rpend=%b data=%h cnt=%0d expected 1 9999 1", rpend[2], rd(2), pend_cnt);
    end
  endtask

  task automatic test_sweep();
    int busy_cycles;
    int nonzero;
    for (int i = 0; i < 16; i++) begin
      wena = 1'b1;
      waddr = AW'(i);
      wdata = 64'h100 + 64'(i);
      step();
    end
    wena = 1'b0;
    iss_addr = 4'd0;
    iss_ena = 1'b1;
    step();
    iss_addr = 4'd5;
    step();
    iss_addr = 4'd10;
    step();
    iss_addr = 4'd15;
    step();
    iss_ena = 1'b0;
    dbg_addr = 4'd2;
    #1;
    checks++;
    if (pend_cnt !== 5'd4 || dbg_data !== 64'h102) begin
      failures++;
      $display("[TB] FAIL sweep_setup: got cnt=%0d dbg=%h expected 4 102", pend_cnt, dbg_data);
    end
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cycles = 0;
    while (clr_busy === 1'b1 && busy_cycles < 40) begin
      if (busy_cycles == 5) begin
        wena = 1'b1;
        waddr = 4'd2;
        wdata = 64'hBAD;
        iss_ena = 1'b1;
        iss_addr = 4'd1;
        raddr = {4'd1, 4'd1, 4'd2};
        #1;
        checks++;
        if (rd(0) !== 64'h0 || pend_cnt !== 5'd3) begin
          failures++;
          $display("[TB] FAIL sweep_mid: got data=%h cnt=%0d expected 0 3", rd(0), pend_cnt);
        end
      end
      if (busy_cycles == 7) begin
        clr_start = 1'b1;
      end
      busy_cycles++;
      step();
      wena = 1'b0;
      iss_ena = 1'b0;
      clr_start = 1'b0;
    end
    checks++;
    if (busy_cycles != 16) begin
      failures++;
      $display("[TB] FAIL sweep_busy_len: got %0d expected 16", busy_cycles);
    end
    checks++;
    if (clr_done !== 1'b1 || pend_cnt !== 5'd0) begin
      failures++;
      $display("[TB] FAIL sweep_done: got done=%b cnt=%0d expected 1 0", clr_done, pend_cnt);
    end
    step();
    checks++;
    if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sweep_done_pulse: got done=%b busy=%b expected 0 0", clr_done, clr_busy);
    end
    nonzero = 0;
    for (int a = 0; a < 16; a++) begin
      dbg_addr = AW'(a);
      #1;
      if (dbg_data !== 64'h0) nonzero++;
    end
    checks++;
    if (nonzero != 0) begin
      failures++;
      $display("[TB] FAIL sweep_regs_zero: got %0d nonzero entries expected 0", nonzero);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cycles;
    wena = 1'b1;
    waddr = 4'd12;
    wdata = 64'hC0C0;
    step();
    wena = 1'b0;
    iss_ena = 1'b1;
    iss_addr = 4'd11;
    step();
    iss_ena = 1'b0;
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (5) step();
    dbg_addr = 4'd12;
    #1;
    checks++;
    if (clr_busy !== 1'b1 || dbg_data !== 64'hC0C0) begin
      failures++;
      $display("[TB] FAIL midrst_before: got busy=%b dbg=%h expected 1 c0c0", clr_busy, dbg_data);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0 || pend_cnt !== 5'd0 || dbg_data !== 64'h0) begin
      failures++;
      $display("[TB] FAIL midrst_async: got busy=%b cnt=%0d dbg=%h expected 0 0 0", clr_busy, pend_cnt, dbg_data);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_idle: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
    end
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cycles = 0;
    while (clr_busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      step();
    end
    checks++;
    if (busy_cycles != 16 || clr_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_resweep: got len=%0d done=%b expected 16 1", busy_cycles, clr_done);
    end
  endtask

  task automatic test_multiport_debug();
    wena = 1'b1;
    waddr = 4'd4;
    wdata = 64'h44;
    step();
    wena = 1'b0;
    raddr = {4'd4, 4'd4, 4'd4};
    dbg_addr = 4'd4;
    #1;
    for (int p = 0; p < NR; p++) begin
      checks++;
      if (rd(p) !== 64'h44) begin
        failures++;
        $display("[TB] FAIL multiport%0d: got %h expected 44", p, rd(p));
      end
    end
    checks++;
    if (dbg_data !== 64'h44) begin
      failures++;
      $display("[TB] FAIL debug_read: got %h expected 44", dbg_data);
    end
    wena = 1'b1;
    wdata = 64'h55;
    #1;
    checks++;
    if (rd(0) !== 64'h55 || rd(1) !== 64'h55 || rd(2) !== 64'h55) begin
      failures++;
      $display("[TB] FAIL multiport_bypass: got %h %h %h expected 55", rd(0), rd(1), rd(2));
    end
    checks++;
    if (dbg_data !== 64'h44 || dbg_data_nb !== 64'h44 || rd_nb(1) !== 64'h44) begin
      failures++;
      $display("[TB] FAIL debug_no_bypass: got %h/%h/%h expected 44", dbg_data, dbg_data_nb, rd_nb(1));
    end
    step();
    wena = 1'b0;
    #1;
    checks++;
    if (dbg_data !== 64'h55) begin
      failures++;
      $display("[TB] FAIL debug_after_write: got %h expected 55", dbg_data);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    raddr = '0;
    wena = 1'b0;
    waddr = '0;
    wdata = '0;
    iss_ena = 1'b0;
    iss_addr = '0;
    clr_start = 1'b0;
    dbg_addr = '0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_sweep();
    test_reset_mid_sweep();
    test_multiport_debug();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
